dvr_key_sync_source: RTL and testbench

//  Master end of dvr_key_if: produces the key/sync stream consumed by the AES encryptor's slave port.

---
 rtl/aes_pkg.sv | 14 +
 rtl/dvr_key_if.sv | 26 ++
 rtl/sync_ctr_inc.sv | 20 ++
 rtl/dvr_key_sync_source.sv | 101 ++++++++++
 tb/tb_dvr_key_sync_source.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-side types for the DVR key/sync path.
// Block width, block type and key/sync source FSM states.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [8*AES_BLOCK_BYTES-1:0] aes_block_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } dvr_src_state_t;

endpackage

// File: rtl/dvr_key_if.sv
// Key/sync handshake bundle between the key source and the encryptor.
// The source drives key, sync and valid; the encryptor drives rdy.
interface dvr_key_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] key;
  logic [8*DATA_WIDTH_IN_BYTES-1:0] sync;
  logic                             valid;
  logic                             rdy;

  modport master (
    output key,
    output sync,
    output valid,
    input  rdy
  );

  modport slave (
    input  key,
    input  sync,
    input  valid,
    output rdy
  );

endinterface

// File: rtl/sync_ctr_inc.sv
// CTR-mode counter step: bumps the low CTR_WIDTH bits of a sync block.
// The carry out of the counter field is dropped; upper bits pass through.
module sync_ctr_inc #(
  parameter int W         = 128,
  parameter int CTR_WIDTH = 32
) (
  input  logic [W-1:0] sync_in,
  output logic [W-1:0] sync_out
);

  if (CTR_WIDTH >= W) begin : g_full
    assign sync_out = sync_in + W'(1);
  end else begin : g_part
    assign sync_out = {
      sync_in[W-1:CTR_WIDTH],
      sync_in[CTR_WIDTH-1:0] + CTR_WIDTH'(1)
    };
  end

endmodule

// File: rtl/dvr_key_sync_source.sv
// Master end of dvr_key_if: issues a run of key/sync words to the
// encryptor, stepping the CTR field of sync after every accepted word.
module dvr_key_sync_source
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = AES_BLOCK_BYTES,
  parameter int CTR_WIDTH           = 32,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] cfg_key,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] cfg_sync,
  input  logic                             cfg_load,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             num_blocks,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  dvr_key_if.master                        key_if
);

  localparam int W = 8*DATA_WIDTH_IN_BYTES;

  dvr_src_state_t       state;
  logic [W-1:0]         key_q;
  logic [W-1:0]         sync_q;
  logic [W-1:0]         sync_nxt;
  logic [CNT_WIDTH-1:0] rem_q;
  logic                 valid_q;
  logic                 xfer;

  assign xfer = valid_q & key_if.rdy;

  sync_ctr_inc #(
    .W         (W),
    .CTR_WIDTH (CTR_WIDTH)
  ) u_inc (
    .sync_in  (sync_q),
    .sync_out (sync_nxt)
  );

  assign key_if.key   = key_q;
  assign key_if.sync  = sync_q;
  assign key_if.valid = valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_q   <= '0;
      sync_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_load) begin
            key_q  <= cfg_key;
            sync_q <= cfg_sync;
          end
          if (start) begin
            if (num_blocks != '0) begin
              state   <= ACTIVE;
              rem_q   <= num_blocks;
              valid_q <= 1'b1;
              busy    <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          // abort wins over a same-cycle handshake: no step, no done
          if (abort) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
          end else if (xfer) begin
            sync_q <= sync_nxt;
            rem_q  <= rem_q - CNT_WIDTH'(1);
            if (rem_q == CNT_WIDTH'(1)) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvr_key_sync_source.sv
// Bench for dvr_key_sync_source: vector table, directed corners and
// randomized runs scored against a per-run expected word list.
module tb_dvr_key_sync_source;
  import aes_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  aes_block_t  cfg_key;
  aes_block_t  cfg_sync;
  logic        cfg_load;
  logic        start;
  logic [15:0] num_blocks;
  logic        abort;
  logic        busy;
  logic        done;

  dvr_key_if #(.DATA_WIDTH_IN_BYTES(16)) kif();

  dvr_key_sync_source #(
    .DATA_WIDTH_IN_BYTES (16),
    .CTR_WIDTH           (32),
    .CNT_WIDTH           (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_key    (cfg_key),
    .cfg_sync   (cfg_sync),
    .cfg_load   (cfg_load),
    .start      (start),
    .num_blocks (num_blocks),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .key_if     (kif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  aes_block_t m_key;
  aes_block_t m_sync;

  typedef struct {
    bit          st;
    logic [15:0] n;
    bit          rdy;
    bit          ev;
    bit          eb;
    bit          ed;
    bit          cs;
    logic [31:0] low;
  } vec_t;

  vec_t tv[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic aes_block_t adv(input aes_block_t s, input int k);
    adv = {s[127:32], s[31:0] + 32'(k)};
  endfunction

  function automatic aes_block_t rnd128();
    rnd128 = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_run(input logic [15:0] n, input int pct,
                        input logic [31:0] pat, input int plen,
                        input int abort_after, input bit junk,
                        input bit ld, input aes_block_t lk,
                        input aes_block_t ls);
    int xf;
    bit fin;
    bit rd;
    bit ab;
    aes_block_t base;
    if (ld) begin
      cfg_load = 1'b1;
      cfg_key  = lk;
      cfg_sync = ls;
      m_key    = lk;
      m_sync   = ls;
    end
    start      = 1'b1;
    num_blocks = n;
    tick();
    start    = 1'b0;
    cfg_load = 1'b0;
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_valid", kif.valid, 0);
      tick();
      chk("zero_done_drop", done, 0);
      chk("zero_valid_late", kif.valid, 0);
      return;
    end
    base = m_sync;
    xf   = 0;
    fin  = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      chk("run_valid", kif.valid, 1);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_key", kif.key, m_key);
      chk("run_sync", kif.sync, adv(base, xf));
      if (plen > 0) rd = (cyc < plen) ? pat[cyc] : 1'b1;
      else          rd = ($urandom_range(99) < pct);
      ab       = (xf == abort_after);
      kif.rdy  = rd;
      abort    = ab;
      if (junk) begin
        cfg_load   = 1'b1;
        cfg_key    = rnd128();
        cfg_sync   = rnd128();
        start      = 1'b1;
        num_blocks = 16'($urandom);
      end
      tick();
      abort    = 1'b0;
      kif.rdy  = 1'b0;
      cfg_load = 1'b0;
      start    = 1'b0;
      if (ab) begin
        chk("abort_valid", kif.valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        fin = 1'b1;
      end else if (rd) begin
        xf++;
        if (xf == int'(n)) begin
          chk("end_valid", kif.valid, 0);
          chk("end_busy", busy, 0);
          chk("end_done", done, 1);
          tick();
          chk("end_done_drop", done, 0);
          fin = 1'b1;
        end
      end
    end
    if (!fin) begin
      fails++;
      tests++;
      $display("FAIL run_timeout: got %0d xfers required %0d", xf, n);
    end
    m_sync = adv(base, xf);
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_key    = '0;
    cfg_sync   = '0;
    cfg_load   = 1'b0;
    start      = 1'b1;
    num_blocks = 16'd4;
    abort      = 1'b0;
    kif.rdy    = 1'b1;
    m_key      = '0;
    m_sync     = '0;

    repeat (3) tick();
    chk("rst_valid", kif.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_key", kif.key, 0);
    chk("rst_sync", kif.sync, 0);
    start   = 1'b0;
    kif.rdy = 1'b0;
    rst_n   = 1'b1;
    tick();
    chk("rst_idle_valid", kif.valid, 0);

    m_key  = 128'h000102030405060708090a0b0c0d0e0f;
    m_sync = 128'hf0f1f2f3f4f5f6f7f8f9fafb00000000;
    cfg_key  = m_key;
    cfg_sync = m_sync;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;

    tv[0] = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0};
    tv[1] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1};
    tv[2] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2};
    tv[3] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd3};
    tv[4] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
    tv[5] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    for (int i = 0; i < 6; i++) begin
      start      = tv[i].st;
      num_blocks = tv[i].n;
      kif.rdy    = tv[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), kif.valid, tv[i].ev);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].eb);
      chk($sformatf("vec%0d_done", i), done, tv[i].ed);
      if (tv[i].cs) begin
        chk($sformatf("vec%0d_sync", i), kif.sync,
            {m_sync[127:32], tv[i].low});
        chk($sformatf("vec%0d_key", i), kif.key, m_key);
      end
    end
    start   = 1'b0;
    kif.rdy = 1'b0;
    m_sync  = adv(m_sync, 4);

    // backpressure: rdy 0,0,1,0,1,1
    do_run(16'd3, 0, 32'b110100, 6, -1, 1'b0, 1'b0, '0, '0);

    do_run(16'd3, 100, 0, 0, -1, 1'b0, 1'b1, rnd128(),
           {96'haaaaaaaaaaaaaaaaaaaaaaaa, 32'hfffffffe});
    chk("wrap_post", m_sync, {96'haaaaaaaaaaaaaaaaaaaaaaaa, 32'h1});

    do_run(16'd0, 100, 0, 0, -1, 1'b0, 1'b0, '0, '0);
    do_run(16'd2, 100, 0, 0, -1, 1'b0, 1'b1, m_key,
           128'h11112222333344445555666677778888);

    // abort after 2 xfers with cfg_load/start hammered while busy
    do_run(16'd5, 100, 0, 0, 2, 1'b1, 1'b0, '0, '0);
    do_run(16'd2, 70, 0, 0, -1, 1'b0, 1'b0, '0, '0);

    start      = 1'b1;
    num_blocks = 16'd5;
    tick();
    start   = 1'b0;
    kif.rdy = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", kif.valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_key", kif.key, 0);
    chk("mrst_sync", kif.sync, 0);
    rst_n   = 1'b1;
    kif.rdy = 1'b0;
    tick();
    chk("mrst_no_done", done, 0);
    m_key  = '0;
    m_sync = '0;
    do_run(16'd2, 100, 0, 0, -1, 1'b0, 1'b0, '0, '0);

    for (int r = 0; r < 30; r++) begin
      automatic logic [15:0] n = 16'($urandom_range(6));
      automatic int pct = $urandom_range(100, 30);
      automatic int ab = ($urandom_range(3) == 0) ?
                         $urandom_range(int'(n)) : -1;
      automatic bit jk = 1'($urandom_range(1));
      automatic bit ld = 1'($urandom_range(1));
      automatic aes_block_t ls = rnd128();
      if ($urandom_range(2) == 0)
        ls[31:0] = 32'hffffffff - 32'($urandom_range(3));
      do_run(n, pct, 0, 0, ab, jk, ld, rnd128(), ls);
      repeat ($urandom_range(2)) begin
        kif.rdy = 1'($urandom_range(1));
        tick();
        chk("gap_valid", kif.valid, 0);
        chk("gap_busy", busy, 0);
      end
      kif.rdy = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
